// File: rtl/touch_frame_sequencer_if.sv
// Sample and frame-update signals between touchpad_controller, the sequencer and tft_driver.
// The master modport drives samples and frame pulses; the slave modport is the sequencer.
interface touch_frame_sequencer_if;
   logic        sample_valid;
   logic [11:0] touch_x;
   logic [11:0] touch_y;
   logic [11:0] touch_z;
   logic        new_frame;
   logic [8:0]  pos_x;
   logic [8:0]  pos_y;
   logic        touching;
   logic        press_evt;
   logic        release_evt;

   modport master (
      output sample_valid, touch_x, touch_y, touch_z, new_frame,
      input  pos_x, pos_y, touching, press_evt, release_evt
   );

   modport slave (
      input  sample_valid, touch_x, touch_y, touch_z, new_frame,
      output pos_x, pos_y, touching, press_evt, release_evt
   );
endinterface

// File: rtl/touch_frame_sequencer.sv
// Debounces touch pressure, averages tracked samples into screen coordinates and
// releases them to the display only on frame boundaries.
module touch_frame_sequencer #(
   parameter int unsigned Z_THRESH   = 256,
   parameter int unsigned DEBOUNCE_N = 4,
   parameter int unsigned AVG_LOG2   = 2,
   parameter int unsigned X_OFFSET   = 150,
   parameter int unsigned Y_OFFSET   = 300,
   parameter int unsigned SHIFT      = 2,
   parameter int unsigned X_MAX      = 479,
   parameter int unsigned Y_MAX      = 271
) (
   input  logic                   cclk,
   input  logic                   reset,
   touch_frame_sequencer_if.slave bus_io
);

   localparam int unsigned AccW   = 12 + AVG_LOG2;
   localparam int unsigned NumAvg = 1 << AVG_LOG2;

   typedef enum logic [1:0] {StIdle, StDebounce, StTrack} state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      rel_cnt_q, rel_cnt_d;
   logic [4:0]      smp_cnt_q, smp_cnt_d;
   logic [AccW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic [8:0]      pend_x_q, pend_x_d, pend_y_q, pend_y_d;
   logic            pend_flag_q, pend_flag_d;
   logic [8:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic            touching_q, touching_d;
   logic            press_q, press_d, release_q, release_d;

   logic            pressed, avg_done, in_track;
   logic [AccW-1:0] sum_x, sum_y;
   logic [11:0]     avg_x, avg_y;

   // Clamp happens on the 12-bit value so large raw inputs cannot wrap into range.
   function automatic logic [8:0] convert(input logic [11:0] avg, input int unsigned off,
                                          input int unsigned max_v);
      logic [11:0] d;
      logic [11:0] p;
      d = (avg >= 12'(off)) ? avg - 12'(off) : 12'd0;
      p = d >> SHIFT;
      if (p > 12'(max_v)) p = 12'(max_v);
      return p[8:0];
   endfunction

   assign pressed  = bus_io.touch_z >= 12'(Z_THRESH);
   assign in_track = (state_q == StTrack);
   assign sum_x    = acc_x_q + AccW'(bus_io.touch_x);
   assign sum_y    = acc_y_q + AccW'(bus_io.touch_y);
   assign avg_x    = 12'(sum_x >> AVG_LOG2);
   assign avg_y    = 12'(sum_y >> AVG_LOG2);

   always_ff @(posedge cclk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus_io.sample_valid && pressed) state_d = StDebounce;
         end
         StDebounce: begin
            if (bus_io.sample_valid) begin
               if (!pressed)                          state_d = StIdle;
               else if (cnt_q + 4'd1 == 4'(DEBOUNCE_N)) state_d = StTrack;
            end
         end
         StTrack: begin
            if (bus_io.sample_valid && !pressed && (rel_cnt_q + 4'd1 == 4'(DEBOUNCE_N)))
               state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath and frame-update next state; averaging state is held clear outside TRACK.
   always_comb begin
      cnt_d     = cnt_q;
      rel_cnt_d = rel_cnt_q;
      smp_cnt_d = smp_cnt_q;
      acc_x_d   = acc_x_q;
      acc_y_d   = acc_y_q;
      pend_x_d  = pend_x_q;
      pend_y_d  = pend_y_q;
      avg_done  = 1'b0;
      unique case (state_q)
         StIdle, StDebounce: begin
            rel_cnt_d = '0;
            smp_cnt_d = '0;
            acc_x_d   = '0;
            acc_y_d   = '0;
            if (bus_io.sample_valid) cnt_d = pressed ? cnt_q + 4'd1 : 4'd0;
         end
         StTrack: begin
            cnt_d = '0;
            if (bus_io.sample_valid) begin
               if (pressed) begin
                  rel_cnt_d = '0;
                  if (smp_cnt_q == 5'(NumAvg - 1)) begin
                     avg_done  = 1'b1;
                     smp_cnt_d = '0;
                     acc_x_d   = '0;
                     acc_y_d   = '0;
                     pend_x_d  = convert(avg_x, X_OFFSET, X_MAX);
                     pend_y_d  = convert(avg_y, Y_OFFSET, Y_MAX);
                  end else begin
                     smp_cnt_d = smp_cnt_q + 5'd1;
                     acc_x_d   = sum_x;
                     acc_y_d   = sum_y;
                  end
               end else begin
                  rel_cnt_d = rel_cnt_q + 4'd1;
               end
            end
         end
         default: ;
      endcase

      // A result completing on a frame cycle stays pending for the following frame.
      pend_flag_d = pend_flag_q;
      if (bus_io.new_frame) pend_flag_d = 1'b0;
      if (avg_done)         pend_flag_d = 1'b1;

      pos_x_d    = (bus_io.new_frame && pend_flag_q) ? pend_x_q : pos_x_q;
      pos_y_d    = (bus_io.new_frame && pend_flag_q) ? pend_y_q : pos_y_q;
      touching_d = bus_io.new_frame ? in_track : touching_q;
      press_d    = bus_io.new_frame & in_track & ~touching_q;
      release_d  = bus_io.new_frame & ~in_track & touching_q;
   end

   always_ff @(posedge cclk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         rel_cnt_q   <= '0;
         smp_cnt_q   <= '0;
         acc_x_q     <= '0;
         acc_y_q     <= '0;
         pend_x_q    <= '0;
         pend_y_q    <= '0;
         pend_flag_q <= 1'b0;
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         touching_q  <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         smp_cnt_q   <= smp_cnt_d;
         acc_x_q     <= acc_x_d;
         acc_y_q     <= acc_y_d;
         pend_x_q    <= pend_x_d;
         pend_y_q    <= pend_y_d;
         pend_flag_q <= pend_flag_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         touching_q  <= touching_d;
         press_q     <= press_d;
         release_q   <= release_d;
      end
   end

   always_comb begin
      bus_io.pos_x       = pos_x_q;
      bus_io.pos_y       = pos_y_q;
      bus_io.touching    = touching_q;
      bus_io.press_evt   = press_q;
      bus_io.release_evt = release_q;
   end

endmodule

// File: tb/tb_touch_frame_sequencer.sv
// Directed bench for touch_frame_sequencer: table of press/frame/release vectors
// plus hand-written sequences for frame coincidence, overwrite and async reset.
module tb_touch_frame_sequencer;

   logic cclk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   touch_frame_sequencer_if bus ();

   touch_frame_sequencer dut (
      .cclk   (cclk),
      .reset  (reset),
      .bus_io (bus.slave)
   );

   always #5 cclk = ~cclk;

   typedef struct {
      int x;
      int y;
      int z;
      int ex;
      int ey;
      int et;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge cclk);
      #1;
   endtask

   task automatic send(input int x, input int y, input int z, input logic nf);
      bus.sample_valid = 1'b1;
      bus.touch_x      = 12'(x);
      bus.touch_y      = 12'(y);
      bus.touch_z      = 12'(z);
      bus.new_frame    = nf;
      tick();
      bus.sample_valid = 1'b0;
      bus.new_frame    = 1'b0;
   endtask

   task automatic frame();
      bus.new_frame = 1'b1;
      tick();
      bus.new_frame = 1'b0;
   endtask

   task automatic chk_pos(input string nm, input int ex, input int ey);
      chk({nm, " pos_x"}, int'(bus.pos_x), ex);
      chk({nm, " pos_y"}, int'(bus.pos_y), ey);
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.touch_x      = '0;
      bus.touch_y      = '0;
      bus.touch_z      = '0;
      bus.new_frame    = 1'b0;

      tbl[0] = '{x: 750,  y: 1300, z: 1000, ex: 150, ey: 250, et: 1};
      tbl[1] = '{x: 100,  y: 200,  z: 1000, ex: 0,   ey: 0,   et: 1};
      tbl[2] = '{x: 4095, y: 4095, z: 4095, ex: 479, ey: 271, et: 1};
      tbl[3] = '{x: 150,  y: 300,  z: 256,  ex: 0,   ey: 0,   et: 1};
      tbl[4] = '{x: 600,  y: 1100, z: 255,  ex: 0,   ey: 0,   et: 0};
      tbl[5] = '{x: 154,  y: 304,  z: 500,  ex: 1,   ey: 1,   et: 1};
      tbl[6] = '{x: 750,  y: 1300, z: 1000, ex: 150, ey: 250, et: 1};

      repeat (2) tick();
      chk("reset pos_x", int'(bus.pos_x), 0);
      chk("reset touching", int'(bus.touching), 0);
      reset = 1'b0;
      tick();
      chk_pos("post reset", 0, 0);
      chk("post reset evts", int'({bus.press_evt, bus.release_evt}), 0);

      // Each row: debounce + one average, frame, then release when the press was valid.
      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < 8; k++) send(tbl[i].x, tbl[i].y, tbl[i].z, 1'b0);
         frame();
         chk($sformatf("row%0d touching", i), int'(bus.touching), tbl[i].et);
         chk_pos($sformatf("row%0d", i), tbl[i].ex, tbl[i].ey);
         chk($sformatf("row%0d press_evt", i), int'(bus.press_evt), tbl[i].et);
         tick();
         chk($sformatf("row%0d press_evt drop", i), int'(bus.press_evt), 0);
         if (tbl[i].et != 0) begin
            for (int k = 0; k < 4; k++) send(0, 0, 0, 1'b0);
            frame();
            chk($sformatf("row%0d rel touching", i), int'(bus.touching), 0);
            chk($sformatf("row%0d release_evt", i), int'(bus.release_evt), 1);
            chk_pos($sformatf("row%0d rel hold", i), tbl[i].ex, tbl[i].ey);
            tick();
            chk($sformatf("row%0d release_evt drop", i), int'(bus.release_evt), 0);
         end
      end

      // Glitch mid-debounce restarts the count.
      for (int k = 0; k < 3; k++) send(750, 1300, 1000, 1'b0);
      send(750, 1300, 100, 1'b0);
      for (int k = 0; k < 3; k++) send(1150, 700, 1000, 1'b0);
      frame();
      chk("glitch touching", int'(bus.touching), 0);
      chk("glitch press_evt", int'(bus.press_evt), 0);
      chk_pos("glitch hold", 150, 250);
      send(0, 0, 0, 1'b0);

      // Average completing on a frame cycle is deferred to the next frame.
      for (int k = 0; k < 8; k++) send(750, 1300, 1000, 1'b0);
      for (int k = 0; k < 3; k++) send(1150, 700, 1000, 1'b0);
      send(1150, 700, 1000, 1'b1);
      chk_pos("coincide old", 150, 250);
      chk("coincide touching", int'(bus.touching), 1);
      chk("coincide press_evt", int'(bus.press_evt), 1);
      frame();
      chk_pos("coincide next", 250, 100);
      chk("coincide press_evt once", int'(bus.press_evt), 0);

      // Latest unconsumed average wins; sum 3803 >> 2 truncates to 950.
      for (int k = 0; k < 4; k++) send(350, 500, 1000, 1'b0);
      send(951, 901, 1000, 1'b0);
      send(951, 901, 1000, 1'b0);
      send(951, 901, 1000, 1'b0);
      send(950, 900, 1000, 1'b0);
      frame();
      chk_pos("overwrite", 200, 150);
      frame();
      chk_pos("no pending hold", 200, 150);

      // Async reset while tracking with a result pending.
      for (int k = 0; k < 4; k++) send(350, 500, 1000, 1'b0);
      @(posedge cclk);
      #3 reset = 1'b1;
      #1;
      chk_pos("async reset", 0, 0);
      chk("async reset touching", int'(bus.touching), 0);
      #10 reset = 1'b0;
      tick();
      frame();
      chk_pos("after reset frame", 0, 0);
      chk("after reset touching", int'(bus.touching), 0);
      chk("after reset press_evt", int'(bus.press_evt), 0);
      for (int k = 0; k < 3; k++) send(750, 1300, 1000, 1'b0);
      frame();
      chk("after reset idle", int'(bus.touching), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
